itcm_ifu_rsp: RTL and testbench
===============================

# itcm_ifu_rsp

ITCM instruction-side responder: the memory end of the IFU-to-ITCM fetch channel. Accepts IFU fetch commands, drives the single-port ITCM SRAM read port, and returns 32-bit fetch data with an error flag. Reports `ifu2itcm_holdup` so the IFU can reuse a lane that is still on the SRAM output. The LSU has priority on the SRAM, and a response held off by backpressure is buffered so it survives an LSU access.

## Interface
Parameters:
- `AW`, 16: ITCM byte-address width (`ITCM_ADDR_WIDTH`).
- `RAM_AW`, 14: SRAM word-address width (`ITCM_RAM_AW`). `AW` = `RAM_AW` + 2.
- `DW`, 32: SRAM/lane data width (`ITCM_DATA_WIDTH`). Fixed at 32.
- `RAM_DP`, 16384: SRAM depth in words. Used only under `ITCM_ADDR_CHK_EN`.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `ifu2itcm_cmd_valid`, in, 1: fetch command valid.
- `ifu2itcm_cmd_ready`, out, 1: fetch command ready.
- `ifu2itcm_addr`, in, AW: fetch byte address; bits [1:0] ignored.
- `ifu2itcm_rsp_valid`, out, 1: response valid.
- `ifu2itcm_rsp_ready`, in, 1: response ready.
- `ifu2itcm_rsp_err`, out, 1: response error.
- `ifu2itcm_rsp_rdata`, out, DW: fetched lane.
- `ifu2itcm_holdup`, out, 1: SRAM output still holds the last IFU-read lane.
- `lsu_ram_req`, in, 1: the LSU owns the SRAM this cycle.
- `itcm_ram_cs`, out, 1: SRAM chip select for an IFU read.
- `itcm_ram_addr`, out, RAM_AW: SRAM word address, equal to `ifu2itcm_addr[RAM_AW+1:2]`.
- `itcm_ram_dout`, in, DW: SRAM read data. Valid one cycle after `cs`, and held until the next access.

## Operation
- States:
  - IDLE: no response pending.
  - RSP_RAM: response pending, data taken live from `itcm_ram_dout`.
  - RSP_BUF: response pending, data taken from the internal 32-bit `rsp_buf`.
- `ifu2itcm_cmd_ready = ~lsu_ram_req & (~ifu2itcm_rsp_valid | ifu2itcm_rsp_ready)`.
- Accept (`cmd_valid & cmd_ready`):
  - Asserts `itcm_ram_cs` combinationally and latches `err_r`.
  - The next state is RSP_RAM.
- Transitions:
  - RSP_RAM with no response handshake: go to RSP_BUF and load `rsp_buf <= itcm_ram_dout`.
  - RSP_RAM or RSP_BUF with a response handshake: go to RSP_RAM on a new accept in the same cycle, otherwise to IDLE.
- `ifu2itcm_rsp_valid` = state ≠ IDLE.
- `ifu2itcm_rsp_rdata`:
  - `itcm_ram_dout` in RSP_RAM, `rsp_buf` in RSP_BUF.
  - 0 when `err_r`=1 or in IDLE.
- `ifu2itcm_rsp_err` = `err_r` while valid, else 0.
- `itcm_ram_cs` is 0 whenever `lsu_ram_req`=1; the LSU always wins.
- `holdup_r` update rules:
  - Set on the cycle after an IFU `cs`.
  - Cleared on the cycle after any `lsu_ram_req`.
  - Unchanged by error commands (no SRAM access) and by response handshakes.
  - `ifu2itcm_holdup = holdup_r`.
- Simultaneous events:
  - `lsu_ram_req` together with `cmd_valid`: the command stalls.
  - `lsu_ram_req` while in RSP_RAM unaccepted: `rsp_buf` captures that same cycle, before the LSU data lands, so the response is intact.

## Timing
- Reset values:
  - state = IDLE, `rsp_valid` = 0, `rsp_err` = 0, `rsp_rdata` = 0, `holdup` = 0, `rsp_buf` = 0, `err_r` = 0.
  - `itcm_ram_cs` = 0 and `cmd_ready` = 1 (when `lsu_ram_req`=0).
- Latency: a command handshake in cycle N gives `rsp_valid` in N+1. Back-to-back throughput is 1 fetch per cycle with `rsp_ready` held high.
- No combinational path from `rsp_ready` to `rsp_valid`. `cmd_ready` depends combinationally on `rsp_ready` and `lsu_ram_req`.
- Once asserted, `rsp_valid`, `rsp_err` and `rsp_rdata` stay stable until the handshake.
- Reset asserted mid-transaction: everything clears asynchronously and the pending response is discarded.

## Configuration
- `ITCM_ADDR_CHK_EN` defined:
  - A command with `ifu2itcm_addr[AW-1:2] >= RAM_DP` is accepted without `cs`.
  - It responds next cycle with `rsp_err`=1 and `rdata`=0, and `holdup` is unchanged.
- Not defined:
  - `err_r` is always 0.
  - The address wraps modulo the SRAM depth, and every accepted command asserts `cs`.

## Test plan
- Single fetch: addr=0x0010, SRAM word 4 = 0x00A00093, `rsp_ready`=1 → `cs`=1 with `ram_addr`=4 in N; `rsp_valid`=1, `rdata`=0x00A00093, `err`=0 in N+1; `holdup`=1 from N+1.
- Back-to-back: addrs 0x0,0x4,0x8 on consecutive cycles, `rsp_ready`=1 → three responses in consecutive cycles, `cmd_ready` never drops.
- Backpressure plus LSU: fetch 0x0020 (word=0x12345678), `rsp_ready`=0 for 3 cycles, `lsu_ram_req`=1 in N+2 → `rdata` stays 0x12345678 all cycles (RSP_BUF), `holdup`=0 from N+3, `cmd_ready`=0 until the handshake.
- LSU contention: `cmd_valid`=1 and `lsu_ram_req`=1 for 2 cycles → `cmd_ready`=0 and `cs`=0; accepted in the third cycle, response in the fourth.
- `ITCM_ADDR_CHK_EN`, `RAM_DP`=1024: addr=0x1000 → no `cs`, next cycle `rsp_err`=1, `rdata`=0, `holdup` unchanged.
- Reset mid-response: `rst_n`=0 while `rsp_valid`=1 → `rsp_valid`, `holdup` and `rdata` drop to 0 immediately; after release, state is IDLE and `cmd_ready`=1.

Source files
------------

// File: rtl/itcm_ifu_rsp.sv
// ---------------------------------------------------------------------------
// itcm_ifu_rsp
// Memory-side responder of the IFU-to-ITCM fetch channel. It accepts IFU
// fetch commands, drives the single-port ITCM SRAM read port, and returns
// one 32-bit lane per command together with an error flag. The LSU always
// wins the SRAM. A response held by backpressure is moved into a local
// buffer so a later LSU access cannot overwrite it.
//
// Optional feature macro: ITCM_ADDR_CHK_EN
//   defined   : a command whose word address is >= RAM_DP is accepted
//               without touching the SRAM and answered with rsp_err=1.
//   undefined : err is never raised and the address wraps modulo the
//               SRAM depth.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   ifu2itcm_cmd_valid/ready/addr     fetch command channel
//   ifu2itcm_rsp_valid/ready/err/rdata fetch response channel
//   ifu2itcm_holdup         SRAM output still holds the last IFU-read lane
//   lsu_ram_req             LSU owns the SRAM this cycle
//   itcm_ram_cs/addr        SRAM read request for an IFU fetch
//   itcm_ram_dout           SRAM read data (valid the cycle after cs, held)
// ---------------------------------------------------------------------------
module itcm_ifu_rsp #(
    parameter int AW     = 16,
    parameter int RAM_AW = 14,
    parameter int DW     = 32,
    parameter int RAM_DP = 16384
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu2itcm_cmd_valid,
    output logic              ifu2itcm_cmd_ready,
    input  logic [AW-1:0]     ifu2itcm_addr,
    output logic              ifu2itcm_rsp_valid,
    input  logic              ifu2itcm_rsp_ready,
    output logic              ifu2itcm_rsp_err,
    output logic [DW-1:0]     ifu2itcm_rsp_rdata,
    output logic              ifu2itcm_holdup,
    input  logic              lsu_ram_req,
    output logic              itcm_ram_cs,
    output logic [RAM_AW-1:0] itcm_ram_addr,
    input  logic [DW-1:0]     itcm_ram_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RSP_RAM = 2'd1,
        RSP_BUF = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_rsp_buf;
    logic          r_err;
    logic          r_holdup;

    logic          w_accept;
    logic          w_rsp_hs;
    logic          w_addr_err;
    logic          w_buf_load;
    logic [1:0]    w_unused_addr;

    // Byte-offset bits select nothing inside a 32-bit lane.
    assign w_unused_addr = ifu2itcm_addr[1:0];

`ifdef ITCM_ADDR_CHK_EN
    assign w_addr_err = (32'(ifu2itcm_addr[AW-1:2]) >= 32'(RAM_DP));
`else
    assign w_addr_err = 1'b0;
`endif

    assign ifu2itcm_rsp_valid = (r_state != IDLE);
    assign ifu2itcm_cmd_ready = ~lsu_ram_req & (~ifu2itcm_rsp_valid | ifu2itcm_rsp_ready);
    assign w_accept           = ifu2itcm_cmd_valid & ifu2itcm_cmd_ready;
    assign w_rsp_hs           = ifu2itcm_rsp_valid & ifu2itcm_rsp_ready;

    // cmd_ready already excludes lsu_ram_req, so an accepted command never
    // collides with an LSU access on the SRAM.
    assign itcm_ram_cs   = w_accept & ~w_addr_err;
    assign itcm_ram_addr = ifu2itcm_addr[RAM_AW+1:2];

    // A live-SRAM response that is not taken this cycle is copied now, while
    // the SRAM output still holds it; any LSU access this cycle lands later.
    assign w_buf_load = (r_state == RSP_RAM) & ~w_rsp_hs;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = RSP_RAM;
            end
            RSP_RAM: begin
                if (w_rsp_hs) w_state_nxt = w_accept ? RSP_RAM : IDLE;
                else          w_state_nxt = RSP_BUF;
            end
            RSP_BUF: begin
                if (w_rsp_hs) w_state_nxt = w_accept ? RSP_RAM : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_buf <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_buf_load) r_rsp_buf <= itcm_ram_dout;
            if (w_accept)   r_err     <= w_addr_err;
        end
    end

    // holdup tracks whether the SRAM output register still carries the last
    // IFU-read lane: an IFU read refreshes it, any LSU access destroys it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_holdup <= 1'b0;
        end else if (lsu_ram_req) begin
            r_holdup <= 1'b0;
        end else if (itcm_ram_cs) begin
            r_holdup <= 1'b1;
        end
    end

    assign ifu2itcm_holdup  = r_holdup;
    assign ifu2itcm_rsp_err = ifu2itcm_rsp_valid & r_err;

    always_comb begin
        ifu2itcm_rsp_rdata = '0;
        if (!r_err) begin
            case (r_state)
                RSP_RAM: ifu2itcm_rsp_rdata = itcm_ram_dout;
                RSP_BUF: ifu2itcm_rsp_rdata = r_rsp_buf;
                default: ifu2itcm_rsp_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_itcm_ifu_rsp.sv
module tb_itcm_ifu_rsp;

    localparam int AW     = 16;
    localparam int RAM_AW = 14;
    localparam int DW     = 32;
`ifdef ITCM_ADDR_CHK_EN
    localparam int DP     = 1024;
`else
    localparam int DP     = 16384;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AW-1:0]     addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_err;
    logic [DW-1:0]     rsp_rdata;
    logic              holdup;
    logic              lsu_req;
    logic              ram_cs;
    logic [RAM_AW-1:0] ram_addr;
    logic [DW-1:0]     ram_dout = '0;

    itcm_ifu_rsp #(.AW(AW), .RAM_AW(RAM_AW), .DW(DW), .RAM_DP(DP)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ifu2itcm_cmd_valid (cmd_valid),
        .ifu2itcm_cmd_ready (cmd_ready),
        .ifu2itcm_addr      (addr),
        .ifu2itcm_rsp_valid (rsp_valid),
        .ifu2itcm_rsp_ready (rsp_ready),
        .ifu2itcm_rsp_err   (rsp_err),
        .ifu2itcm_rsp_rdata (rsp_rdata),
        .ifu2itcm_holdup    (holdup),
        .lsu_ram_req        (lsu_req),
        .itcm_ram_cs        (ram_cs),
        .itcm_ram_addr      (ram_addr),
        .itcm_ram_dout      (ram_dout)
    );

    always #5 clk = ~clk;

    // SRAM contents: constant during the run. An LSU access leaves unrelated
    // garbage on the read port.
    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        if (lsu_req)     ram_dout <= $urandom;
        else if (ram_cs) ram_dout <= mem[ram_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: at most one outstanding response plus the holdup flag.
    bit          m_pend = 1'b0;
    bit          m_err  = 1'b0;
    logic [31:0] m_data = '0;
    bit          m_hold = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [15:0] a);
`ifdef ITCM_ADDR_CHK_EN
        return (32'(a[15:2]) >= 32'(DP));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] rand_addr();
`ifdef ITCM_ADDR_CHK_EN
        return 16'($urandom_range(0, 16'h1FFF));
`else
        return 16'($urandom);
`endif
    endfunction

    // One clock cycle: apply inputs, check every output against the model,
    // then advance the model across the clock edge.
    task automatic cyc(input bit v, input logic [15:0] a, input bit rr, input bit lsu);
        bit e_ready;
        bit acc;
        bit e_err;
        cmd_valid = v;
        addr      = a;
        rsp_ready = rr;
        lsu_req   = lsu;
        #2;
        e_ready = !lsu && (!m_pend || rr);
        acc     = v && e_ready;
        e_err   = is_err(a);
        chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
        chk("ram_cs", 32'(ram_cs), 32'(acc && !e_err));
        if (acc) chk("ram_addr", 32'(ram_addr), 32'(a[15:2]));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_pend));
        chk("rsp_err", 32'(rsp_err), 32'(m_pend && m_err));
        chk("rsp_rdata", rsp_rdata, m_pend ? m_data : 32'h0);
        chk("holdup", 32'(holdup), 32'(m_hold));
        @(posedge clk);
        if (m_pend && rr) m_pend = 1'b0;
        if (acc) begin
            m_pend = 1'b1;
            m_err  = e_err;
            m_data = e_err ? 32'h0 : mem[a[15:2]];
        end
        if (lsu)                m_hold = 1'b0;
        else if (acc && !e_err) m_hold = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[4] = 32'h00A00093;
        mem[8] = 32'h12345678;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        addr      = '0;
        rsp_ready = 1'b0;
        lsu_req   = 1'b0;
        #10;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_holdup", 32'(holdup), 32'h0);
        chk("rst_cs", 32'(ram_cs), 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single fetch of word 4.
        cyc(1, 16'h0010, 1, 0);
        chk("single_rdata", rsp_rdata, 32'h00A00093);
        chk("single_holdup", 32'(holdup), 32'h1);
        cyc(0, 16'h0000, 1, 0);

        // Back-to-back fetches.
        cyc(1, 16'h0000, 1, 0);
        cyc(1, 16'h0004, 1, 0);
        cyc(1, 16'h0008, 1, 0);
        cyc(0, 16'h0000, 1, 0);

        // Backpressure with an LSU access while the response waits.
        cyc(1, 16'h0020, 0, 0);
        cyc(0, 16'h0000, 0, 0);
        cyc(0, 16'h0000, 0, 1);
        chk("bp_rdata_after_lsu", rsp_rdata, 32'h12345678);
        chk("bp_holdup_cleared", 32'(holdup), 32'h0);
        cyc(0, 16'h0000, 0, 0);
        cyc(0, 16'h0000, 1, 0);
        cyc(0, 16'h0000, 1, 0);

        // LSU contention stalls the command for two cycles.
        cyc(1, 16'h0040, 1, 1);
        cyc(1, 16'h0040, 1, 1);
        cyc(1, 16'h0040, 1, 0);
        chk("lsu_cont_rsp_valid", 32'(rsp_valid), 32'h1);
        cyc(0, 16'h0000, 1, 0);

`ifdef ITCM_ADDR_CHK_EN
        // Out-of-range fetch: no SRAM access, error response, holdup kept.
        cyc(1, 16'h0010, 1, 0);
        cyc(1, 16'h1000, 1, 0);
        chk("chk_err", 32'(rsp_err), 32'h1);
        chk("chk_rdata", rsp_rdata, 32'h0);
        chk("chk_holdup", 32'(holdup), 32'h1);
        cyc(0, 16'h0000, 1, 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(bit'($urandom_range(0, 1)), rand_addr(),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
        end

        // Reset while a response is pending.
        cyc(1, 16'h0010, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst_holdup", 32'(holdup), 32'h0);
        chk("midrst_rdata", rsp_rdata, 32'h0);
        m_pend = 1'b0;
        m_err  = 1'b0;
        m_hold = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_cmd_ready", 32'(cmd_ready), 32'h1);
        cyc(1, 16'h0020, 1, 0);
        cyc(0, 16'h0000, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
